board_evaluator: RTL and testbench

Connect-4 board store and move evaluator. It is the producer side of the game-status interface that the game-control FSM consumes.
- Accepts a column drop from the current player and places the piece in the lowest empty row of that column.
- Scans for four-in-a-row through the placed cell.
- Returns one result pulse carrying game_status (NEXT_TURN/GAME_OVER/TIE_GAME), invalid_move and board_full.
- Provides a read port so the display logic can scan the board.

---
 rtl/board_evaluator_if.sv | 34 +++
 rtl/board_evaluator.sv | 189 ++++++++++++++++++
 tb/tb_board_evaluator.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/board_evaluator_if.sv
// Move/result/read-port bundle between the game controller and the board evaluator.
// Latency: none, plain wiring.
// Backpressure: move_ready qualifies move_valid; results are unbuffered one-cycle pulses.
//
// Signals: move_valid/move_ready/move_col/player_turn (move request),
// result_valid/game_status/invalid_move/winner/board_full (move result),
// rd_row/rd_col/rd_cell (combinational board read port).
// master = game controller side, slave = board evaluator side.
interface board_evaluator_if;
  logic       move_valid;
  logic       move_ready;
  logic [2:0] move_col;
  logic       player_turn;
  logic       result_valid;
  logic [1:0] game_status;
  logic       invalid_move;
  logic       winner;
  logic       board_full;
  logic [2:0] rd_row;
  logic [2:0] rd_col;
  logic [1:0] rd_cell;

  modport master (
    output move_valid, move_col, player_turn, rd_row, rd_col,
    input  move_ready, result_valid, game_status, invalid_move, winner,
           board_full, rd_cell
  );

  modport slave (
    input  move_valid, move_col, player_turn, rd_row, rd_col,
    output move_ready, result_valid, game_status, invalid_move, winner,
           board_full, rd_cell
  );
endinterface

// File: rtl/board_evaluator.sv
// Connect-4 board store: drops a piece, scans four directions for a line, reports status.
// Latency: result_valid at T+6 for a placed piece, T+2 for a rejected move (T = accept cycle).
// Backpressure: move_ready only in IDLE; requests while busy or after game end are dropped.
//
// Ports: clk, reset (sync, active-high), clear_board (sync new-game clear),
// bus (board_evaluator_if.slave): move request in, result pulse out,
// board_full level out, combinational rd_row/rd_col -> rd_cell read port.
module board_evaluator #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_board,
  board_evaluator_if.slave     bus
);

  localparam int NCELL = ROWS * COLS;
  localparam int IW    = $clog2(NCELL);
  localparam int FW    = $clog2(NCELL + 1);
  localparam int HW    = $clog2(ROWS + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DROP     = 3'd1;
  localparam logic [2:0] CHECK_H  = 3'd2;
  localparam logic [2:0] CHECK_V  = 3'd3;
  localparam logic [2:0] CHECK_D1 = 3'd4;
  localparam logic [2:0] CHECK_D2 = 3'd5;
  localparam logic [2:0] REPORT   = 3'd6;
  localparam logic [2:0] LOCKED   = 3'd7;

  localparam logic [1:0] ST_NEXT = 2'b00;
  localparam logic [1:0] ST_OVER = 2'b01;
  localparam logic [1:0] ST_TIE  = 2'b10;

  logic [2:0]    state;
  logic [1:0]    cells   [NCELL];   // index = row*COLS + col
  logic [HW-1:0] heights [COLS];
  logic [2:0]    col_q;
  logic          mover_q;
  logic [HW-1:0] row_q;
  logic [FW-1:0] filled_q;
  logic          win_q;
  logic [1:0]    status_q;
  logic          invalid_q;
  logic          winner_q;
  logic          full_q;

  logic          col_ok;
  logic [HW-1:0] col_h;
  logic          drop_ok;
  logic [IW-1:0] wr_idx;
  logic [1:0]    mover_code;
  logic [NCELL-1:0] match;

  assign mover_code = mover_q ? 2'b10 : 2'b01;
  assign col_ok     = int'(col_q) < COLS;
  assign col_h      = col_ok ? heights[col_q] : '0;
  assign drop_ok    = col_ok && (col_h != HW'(ROWS));
  assign wr_idx     = IW'(int'(col_h) * COLS + int'(col_q));

  for (genvar i = 0; i < NCELL; i++) begin : g_match
    assign match[i] = (cells[i] == mover_code);
  end

  // Run length through (row_q,col_q) along the direction owned by the current
  // CHECK state. The placed cell counts as 1; each side stops at the first
  // non-mover cell or the board edge, at most 3 steps.
  int            ln_dr, ln_dc, ln_r, ln_c, ln_run;
  logic          ln_fwd, ln_bwd;
  logic [IW-1:0] ln_idx;
  logic          line_win;

  always_comb begin
    ln_dr  = 0;
    ln_dc  = 1;
    ln_r   = 0;
    ln_c   = 0;
    ln_run = 1;
    ln_fwd = 1'b1;
    ln_bwd = 1'b1;
    ln_idx = '0;
    case (state)
      CHECK_V:  begin ln_dr = 1; ln_dc = 0;  end
      CHECK_D1: begin ln_dr = 1; ln_dc = 1;  end
      CHECK_D2: begin ln_dr = 1; ln_dc = -1; end
      default:  ;
    endcase
    for (int k = 1; k <= 3; k++) begin
      ln_r = int'(row_q) + k * ln_dr;
      ln_c = int'(col_q) + k * ln_dc;
      if (ln_fwd && ln_r >= 0 && ln_r < ROWS && ln_c >= 0 && ln_c < COLS) begin
        ln_idx = IW'(ln_r * COLS + ln_c);
        if (match[ln_idx]) ln_run = ln_run + 1;
        else               ln_fwd = 1'b0;
      end else begin
        ln_fwd = 1'b0;
      end
      ln_r = int'(row_q) - k * ln_dr;
      ln_c = int'(col_q) - k * ln_dc;
      if (ln_bwd && ln_r >= 0 && ln_r < ROWS && ln_c >= 0 && ln_c < COLS) begin
        ln_idx = IW'(ln_r * COLS + ln_c);
        if (match[ln_idx]) ln_run = ln_run + 1;
        else               ln_bwd = 1'b0;
      end else begin
        ln_bwd = 1'b0;
      end
    end
    line_win = (ln_run >= 4);
  end

  always_ff @(posedge clk) begin
    if (reset || clear_board) begin
      state     <= IDLE;
      cells     <= '{default: 2'b00};
      heights   <= '{default: '0};
      col_q     <= '0;
      mover_q   <= 1'b0;
      row_q     <= '0;
      filled_q  <= '0;
      win_q     <= 1'b0;
      status_q  <= ST_NEXT;
      invalid_q <= 1'b0;
      winner_q  <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.move_valid) begin
            col_q   <= bus.move_col;
            mover_q <= bus.player_turn;
            state   <= DROP;
          end
        end
        DROP: begin
          win_q <= 1'b0;
          if (!drop_ok) begin
            invalid_q <= 1'b1;
            status_q  <= ST_NEXT;
            state     <= REPORT;
          end else begin
            cells[wr_idx]  <= mover_code;
            row_q          <= col_h;
            heights[col_q] <= col_h + 1'b1;
            filled_q       <= filled_q + 1'b1;
            if (filled_q == FW'(NCELL - 1)) full_q <= 1'b1;
            invalid_q      <= 1'b0;
            state          <= CHECK_H;
          end
        end
        CHECK_H, CHECK_V, CHECK_D1: begin
          if (line_win) win_q <= 1'b1;
          state <= state + 3'd1;
        end
        CHECK_D2: begin
          // Result fields are loaded here so they are valid during REPORT.
          // A win outranks a full board.
          if (win_q || line_win) begin
            status_q <= ST_OVER;
            winner_q <= mover_q;
          end else if (full_q) begin
            status_q <= ST_TIE;
          end else begin
            status_q <= ST_NEXT;
          end
          state <= REPORT;
        end
        REPORT:  state <= (status_q == ST_NEXT) ? IDLE : LOCKED;
        LOCKED:  state <= LOCKED;
        default: state <= IDLE;
      endcase
    end
  end

  logic          rd_ok;
  logic [IW-1:0] rd_idx;

  assign rd_ok  = (int'(bus.rd_row) < ROWS) && (int'(bus.rd_col) < COLS);
  assign rd_idx = IW'(int'(bus.rd_row) * COLS + int'(bus.rd_col));

  assign bus.rd_cell      = rd_ok ? cells[rd_idx] : 2'b00;
  assign bus.move_ready   = (state == IDLE);
  assign bus.result_valid = (state == REPORT);
  assign bus.game_status  = status_q;
  assign bus.invalid_move = invalid_q;
  assign bus.winner       = winner_q;
  assign bus.board_full   = full_q;

endmodule

// File: tb/tb_board_evaluator.sv
// Directed bench for board_evaluator: drops, invalid moves, all four line directions,
// full-board tie/win, and clear/reset aborting an evaluation.
module tb_board_evaluator;
  logic clk = 1'b0;
  logic reset;
  logic clear_board;
  int   checks = 0;
  int   errors = 0;

  board_evaluator_if bus();

  board_evaluator #(.ROWS(6), .COLS(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear_board (clear_board),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cell_chk(input string tag, input int r, input int c, input logic [1:0] exp);
    bus.rd_row = 3'(r);
    bus.rd_col = 3'(c);
    #1;
    check(tag, 32'(bus.rd_cell), 32'(exp));
  endtask

  task automatic clear_pulse();
    clear_board = 1'b1;
    tick();
    clear_board = 1'b0;
  endtask

  // Issue one move and verify latency, result fields, pulse width and move_ready after.
  task automatic do_move(input string tag, input int col, input logic p,
                         input logic [1:0] st, input logic inv, input logic win);
    int lat;
    check({tag, ".rdy"}, 32'(bus.move_ready), 32'd1);
    bus.move_valid  = 1'b1;
    bus.move_col    = 3'(col);
    bus.player_turn = p;
    tick();
    bus.move_valid = 1'b0;
    lat = 1;
    while (bus.result_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), inv ? 32'd2 : 32'd6);
    check({tag, ".status"}, 32'(bus.game_status), 32'(st));
    check({tag, ".inv"}, 32'(bus.invalid_move), 32'(inv));
    if (st == 2'b01) check({tag, ".winner"}, 32'(bus.winner), 32'(win));
    tick();
    check({tag, ".pulse"}, 32'(bus.result_valid), 32'd0);
    check({tag, ".rdy_after"}, 32'(bus.move_ready), (st == 2'b00) ? 32'd1 : 32'd0);
  endtask

  logic p;
  int   seen;

  initial begin
    reset = 1'b1;
    clear_board = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_col = 3'd0;
    bus.player_turn = 1'b0;
    bus.rd_row = 3'd0;
    bus.rd_col = 3'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst.ready", 32'(bus.move_ready), 32'd1);
    check("rst.rvalid", 32'(bus.result_valid), 32'd0);
    check("rst.status", 32'(bus.game_status), 32'd0);
    check("rst.inv", 32'(bus.invalid_move), 32'd0);
    check("rst.winner", 32'(bus.winner), 32'd0);
    check("rst.full", 32'(bus.board_full), 32'd0);
    cell_chk("rst.cell03", 0, 3, 2'b00);

    // Single drop
    do_move("t1", 3, 1'b0, 2'b00, 1'b0, 1'b0);
    cell_chk("t1.cell03", 0, 3, 2'b01);
    cell_chk("t1.cell13", 1, 3, 2'b00);

    // Full column, then out-of-range column
    clear_pulse();
    for (int i = 0; i < 6; i++) do_move("t2.fill", 0, 1'(i % 2), 2'b00, 1'b0, 1'b0);
    do_move("t2.colfull", 0, 1'b0, 2'b00, 1'b1, 1'b0);
    cell_chk("t2.cell50", 5, 0, 2'b10);
    cell_chk("t2.cell40", 4, 0, 2'b01);
    do_move("t2.col7", 7, 1'b0, 2'b00, 1'b1, 1'b0);
    cell_chk("t2.cell50b", 5, 0, 2'b10);

    // Horizontal win for P1, then locked
    clear_pulse();
    for (int i = 0; i < 3; i++) begin
      do_move("t3.p1", i, 1'b0, 2'b00, 1'b0, 1'b0);
      do_move("t3.p2", 6, 1'b1, 2'b00, 1'b0, 1'b0);
    end
    do_move("t3.win", 3, 1'b0, 2'b01, 1'b0, 1'b0);
    bus.move_valid = 1'b1;
    bus.move_col = 3'd4;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.result_valid || bus.move_ready) seen++;
      tick();
    end
    bus.move_valid = 1'b0;
    check("t3.locked", 32'(seen), 32'd0);
    cell_chk("t3.cell04", 0, 4, 2'b00);
    clear_pulse();
    check("t3.clr_ready", 32'(bus.move_ready), 32'd1);
    cell_chk("t3.clr_cell00", 0, 0, 2'b00);

    // Vertical win for P2 in column 5
    for (int i = 0; i < 3; i++) begin
      do_move("t4v.p1", i % 2, 1'b0, 2'b00, 1'b0, 1'b0);
      do_move("t4v.p2", 5, 1'b1, 2'b00, 1'b0, 1'b0);
    end
    do_move("t4v.p1b", 1, 1'b0, 2'b00, 1'b0, 1'b0);
    do_move("t4v.win", 5, 1'b1, 2'b01, 1'b0, 1'b1);

    // Diagonal / win for P1 ending at (3,3)
    clear_pulse();
    do_move("t4d1", 0, 1'b0, 2'b00, 1'b0, 1'b0);
    do_move("t4d1", 1, 1'b1, 2'b00, 1'b0, 1'b0);
    do_move("t4d1", 2, 1'b1, 2'b00, 1'b0, 1'b0);
    do_move("t4d1", 3, 1'b0, 2'b00, 1'b0, 1'b0);
    do_move("t4d1", 1, 1'b0, 2'b00, 1'b0, 1'b0);
    do_move("t4d1", 2, 1'b0, 2'b00, 1'b0, 1'b0);
    do_move("t4d1", 3, 1'b1, 2'b00, 1'b0, 1'b0);
    do_move("t4d1", 2, 1'b0, 2'b00, 1'b0, 1'b0);
    do_move("t4d1", 3, 1'b1, 2'b00, 1'b0, 1'b0);
    do_move("t4d1.win", 3, 1'b0, 2'b01, 1'b0, 1'b0);

    // Diagonal \ win for P2 ending at (3,0)
    clear_pulse();
    do_move("t4d2", 3, 1'b1, 2'b00, 1'b0, 1'b0);
    do_move("t4d2", 2, 1'b0, 2'b00, 1'b0, 1'b0);
    do_move("t4d2", 1, 1'b0, 2'b00, 1'b0, 1'b0);
    do_move("t4d2", 0, 1'b1, 2'b00, 1'b0, 1'b0);
    do_move("t4d2", 2, 1'b1, 2'b00, 1'b0, 1'b0);
    do_move("t4d2", 1, 1'b1, 2'b00, 1'b0, 1'b0);
    do_move("t4d2", 0, 1'b0, 2'b00, 1'b0, 1'b0);
    do_move("t4d2", 1, 1'b1, 2'b00, 1'b0, 1'b0);
    do_move("t4d2", 0, 1'b0, 2'b00, 1'b0, 1'b0);
    do_move("t4d2.win", 0, 1'b1, 2'b01, 1'b0, 1'b1);

    // Gapped runs X X _ X and X X _ X X are not lines
    clear_pulse();
    do_move("t4g", 0, 1'b0, 2'b00, 1'b0, 1'b0);
    do_move("t4g", 1, 1'b0, 2'b00, 1'b0, 1'b0);
    do_move("t4g", 3, 1'b0, 2'b00, 1'b0, 1'b0);
    do_move("t4g.gap", 4, 1'b0, 2'b00, 1'b0, 1'b0);

    // Full board with no line: cell owner = (row>=3) xor (col odd)
    clear_pulse();
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        p = 1'((r >= 3) ? 1 : 0) ^ 1'(c % 2);
        if (c == 6 && r == 5) begin
          check("t5.full_before", 32'(bus.board_full), 32'd0);
          do_move("t5.tie", c, p, 2'b10, 1'b0, 1'b0);
        end else begin
          do_move("t5.fill", c, p, 2'b00, 1'b0, 1'b0);
        end
      end
    end
    check("t5.full", 32'(bus.board_full), 32'd1);
    clear_pulse();
    check("t5.full_clr", 32'(bus.board_full), 32'd0);

    // Same board but (5,4) and (5,6) go to P1: last drop completes row 5 cols 3..6
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        p = 1'((r >= 3) ? 1 : 0) ^ 1'(c % 2);
        if (r == 5 && (c == 4 || c == 6)) p = 1'b0;
        if (c == 6 && r == 5) do_move("t5.lastwin", c, p, 2'b01, 1'b0, 1'b0);
        else                  do_move("t5.fill2", c, p, 2'b00, 1'b0, 1'b0);
      end
    end
    check("t5.full2", 32'(bus.board_full), 32'd1);
    clear_pulse();
    check("t6.full_clr", 32'(bus.board_full), 32'd0);

    // clear_board at T+3 aborts the evaluation
    check("t6c.rdy", 32'(bus.move_ready), 32'd1);
    bus.move_valid = 1'b1;
    bus.move_col = 3'd2;
    bus.player_turn = 1'b0;
    tick();
    bus.move_valid = 1'b0;
    tick();
    cell_chk("t6c.written", 0, 2, 2'b01);
    tick();
    clear_board = 1'b1;
    tick();
    clear_board = 1'b0;
    check("t6c.ready", 32'(bus.move_ready), 32'd1);
    check("t6c.full", 32'(bus.board_full), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.result_valid) seen++;
      tick();
    end
    check("t6c.no_result", 32'(seen), 32'd0);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) cell_chk("t6c.cell", r, c, 2'b00);

    // reset at T+3 aborts the evaluation
    tick();
    bus.move_valid = 1'b1;
    bus.move_col = 3'd4;
    bus.player_turn = 1'b1;
    tick();
    bus.move_valid = 1'b0;
    tick();
    cell_chk("t6r.written", 0, 4, 2'b10);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6r.ready", 32'(bus.move_ready), 32'd1);
    check("t6r.full", 32'(bus.board_full), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.result_valid) seen++;
      tick();
    end
    check("t6r.no_result", 32'(seen), 32'd0);
    cell_chk("t6r.cell04", 0, 4, 2'b00);

    // Board still usable after the abort
    do_move("t6r.after", 4, 1'b1, 2'b00, 1'b0, 1'b0);
    cell_chk("t6r.cell04b", 0, 4, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
